// File: rtl/background_fill_master.sv
// Avalon-MM master that fills a clipped rectangle of the background
// color-index framebuffer, one pixel write per accepted transfer.
module background_fill_master #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_START,
  input  logic [9:0]        CMD_X,
  input  logic [9:0]        CMD_Y,
  input  logic [9:0]        CMD_W,
  input  logic [9:0]        CMD_H,
  input  logic [DATA_W-1:0] CMD_COLOR,
  input  logic              ABORT,
  output logic              CMD_READY,
  output logic              DONE,
  output logic              AVM_CS,
  output logic              AVM_WRITE,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic [DATA_W-1:0] AVM_WRITEDATA,
  output logic [3:0]        AVM_BYTE_EN,
  input  logic              AVM_WAITREQUEST
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [10:0]       H_END    = 11'(H_RES);
  localparam logic [10:0]       V_END    = 11'(V_RES);
  localparam logic [31:0]       H_BITS   = 32'(H_RES);
  localparam logic [ADDR_W-1:0] H_STRIDE = ADDR_W'(H_RES);

  // Constant-coefficient multiply by H_RES as a shift-add tree.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [9:0] y);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (H_BITS[b]) acc = acc + (ADDR_W'(y) << b);
    end
    return acc;
  endfunction

  state_t              state_q, state_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic [9:0]          w_q, w_d;
  logic [9:0]          h_q, h_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [10:0]         x_end_q, x_end_d;
  logic [10:0]         y_end_q, y_end_d;
  logic [9:0]          col_q, col_d;
  logic [9:0]          row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic                abort_pend_q, abort_pend_d;

  logic [10:0] x_sum;
  logic [10:0] y_sum;
  logic [10:0] col_nxt;
  logic [10:0] row_nxt;
  logic        empty;

  assign x_sum   = {1'b0, x_q} + {1'b0, w_q};
  assign y_sum   = {1'b0, y_q} + {1'b0, h_q};
  assign col_nxt = {1'b0, col_q} + 11'd1;
  assign row_nxt = {1'b0, row_q} + 11'd1;
  assign empty   = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x_q} >= H_END) || ({1'b0, y_q} >= V_END);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    color_d      = color_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    abort_pend_d = abort_pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (CMD_START) begin
          x_d     = CMD_X;
          y_d     = CMD_Y;
          w_d     = CMD_W;
          h_d     = CMD_H;
          color_d = CMD_COLOR;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        x_end_d      = (x_sum > H_END) ? H_END : x_sum;
        y_end_d      = (y_sum > V_END) ? V_END : y_sum;
        abort_pend_d = 1'b0;
        if (empty) begin
          state_d = S_DONE;
        end else begin
          col_d      = x_q;
          row_d      = y_q;
          row_base_d = row_offset(y_q);
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        // An abort seen during a stall is held until the stalled write lands.
        if (ABORT) abort_pend_d = 1'b1;
        if (!AVM_WAITREQUEST) begin
          if (ABORT || abort_pend_q) begin
            state_d = S_DONE;
          end else if (col_nxt < x_end_q) begin
            col_d = col_nxt[9:0];
          end else if (row_nxt < y_end_q) begin
            col_d      = x_q;
            row_d      = row_nxt[9:0];
            row_base_d = row_base_q + H_STRIDE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      color_q      <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      color_q      <= color_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign CMD_READY     = (state_q == S_IDLE);
  assign DONE          = (state_q == S_DONE);
  assign AVM_WRITE     = (state_q == S_WRITE);
  assign AVM_CS        = AVM_WRITE;
  assign AVM_ADDR      = AVM_WRITE ? (row_base_q + ADDR_W'(col_q)) : '0;
  assign AVM_WRITEDATA = color_q;
  assign AVM_BYTE_EN   = 4'b1111;

endmodule

// File: tb/tb_background_fill_master.sv
// Directed self-checking bench for background_fill_master.
module tb_background_fill_master;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_START;
  logic [9:0]  CMD_X, CMD_Y, CMD_W, CMD_H;
  logic [3:0]  CMD_COLOR;
  logic        ABORT;
  logic        CMD_READY;
  logic        DONE;
  logic        AVM_CS;
  logic        AVM_WRITE;
  logic [18:0] AVM_ADDR;
  logic [3:0]  AVM_WRITEDATA;
  logic [3:0]  AVM_BYTE_EN;
  logic        AVM_WAITREQUEST;

  int checks = 0;
  int errors = 0;

  logic [18:0] got_addr[$];
  logic [3:0]  got_data[$];
  int          done_cyc;
  int          wr_seen;

  background_fill_master #(
    .H_RES (640),
    .V_RES (480),
    .ADDR_W(19),
    .DATA_W(4)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .CMD_START      (CMD_START),
    .CMD_X          (CMD_X),
    .CMD_Y          (CMD_Y),
    .CMD_W          (CMD_W),
    .CMD_H          (CMD_H),
    .CMD_COLOR      (CMD_COLOR),
    .ABORT          (ABORT),
    .CMD_READY      (CMD_READY),
    .DONE           (DONE),
    .AVM_CS         (AVM_CS),
    .AVM_WRITE      (AVM_WRITE),
    .AVM_ADDR       (AVM_ADDR),
    .AVM_WRITEDATA  (AVM_WRITEDATA),
    .AVM_BYTE_EN    (AVM_BYTE_EN),
    .AVM_WAITREQUEST(AVM_WAITREQUEST)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents a command for one edge; returns in the SETUP cycle.
  task automatic start_cmd(input int x, input int y, input int w, input int h, input int c);
    CMD_X     = 10'(x);
    CMD_Y     = 10'(y);
    CMD_W     = 10'(w);
    CMD_H     = 10'(h);
    CMD_COLOR = 4'(c);
    CMD_START = 1'b1;
    tick();
    CMD_START = 1'b0;
  endtask

  // Records accepted writes; cycle 0 is the SETUP cycle. Stops in the DONE cycle.
  task automatic collect(input int max_cyc);
    got_addr.delete();
    got_data.delete();
    done_cyc = -1;
    wr_seen  = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (AVM_WRITE) wr_seen++;
      if (AVM_WRITE && !AVM_WAITREQUEST) begin
        got_addr.push_back(AVM_ADDR);
        got_data.push_back(AVM_WRITEDATA);
      end
      if (DONE) begin
        done_cyc = c;
        break;
      end
      tick();
    end
  endtask

  int exp2[4] = '{1278, 1279, 1918, 1919};

  initial begin
    RESET = 1'b0;
    CMD_START = 1'b0;
    CMD_X = '0; CMD_Y = '0; CMD_W = '0; CMD_H = '0; CMD_COLOR = '0;
    ABORT = 1'b0;
    AVM_WAITREQUEST = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst ready", CMD_READY, 1);
    chk("rst done", DONE, 0);
    chk("rst write", AVM_WRITE, 0);
    chk("rst cs", AVM_CS, 0);
    chk("rst addr", AVM_ADDR, 0);
    chk("rst data", AVM_WRITEDATA, 0);
    chk("rst byteen", AVM_BYTE_EN, 4'hF);
    RESET = 1'b1;
    tick();

    // 4x1 fill at origin, exact cycle timing
    start_cmd(0, 0, 4, 1, 5);
    chk("t1 setup ready", CMD_READY, 0);
    chk("t1 setup write", AVM_WRITE, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1 write", AVM_WRITE, 1);
      chk("t1 cs", AVM_CS, 1);
      chk("t1 addr", AVM_ADDR, 32'(i));
      chk("t1 data", AVM_WRITEDATA, 5);
    end
    tick();
    chk("t1 done", DONE, 1);
    chk("t1 done write", AVM_WRITE, 0);
    chk("t1 done ready", CMD_READY, 0);
    tick();
    chk("t1 ready", CMD_READY, 1);
    chk("t1 done drop", DONE, 0);

    // Right-edge clipping across two rows, no bubble at row change
    start_cmd(638, 1, 4, 2, 10);
    collect(20);
    chk("t2 done cyc", done_cyc, 5);
    chk("t2 count", got_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_addr.size()) begin
        chk("t2 addr", got_addr[i], exp2[i]);
        chk("t2 data", got_data[i], 10);
      end
    end
    tick();
    chk("t2 ready", CMD_READY, 1);

    // Bottom-right corner clip: single write to the last pixel
    start_cmd(639, 479, 5, 5, 7);
    collect(20);
    chk("t2b done cyc", done_cyc, 2);
    chk("t2b count", got_addr.size(), 1);
    if (got_addr.size() > 0) chk("t2b addr", got_addr[0], 307199);
    tick();

    // Waitrequest stall on first write; START during WRITE is ignored
    AVM_WAITREQUEST = 1'b1;
    start_cmd(10, 2, 2, 1, 9);
    tick();
    chk("t3 c1 write", AVM_WRITE, 1);
    chk("t3 c1 addr", AVM_ADDR, 1290);
    chk("t3 c1 data", AVM_WRITEDATA, 9);
    CMD_START = 1'b1;
    CMD_X = 10'd100;
    tick();
    chk("t3 c2 addr", AVM_ADDR, 1290);
    chk("t3 c2 ready", CMD_READY, 0);
    CMD_START = 1'b0;
    tick();
    chk("t3 c3 addr", AVM_ADDR, 1290);
    tick();
    AVM_WAITREQUEST = 1'b0;
    chk("t3 c4 write", AVM_WRITE, 1);
    chk("t3 c4 addr", AVM_ADDR, 1290);
    chk("t3 c4 data", AVM_WRITEDATA, 9);
    tick();
    chk("t3 c5 write", AVM_WRITE, 1);
    chk("t3 c5 addr", AVM_ADDR, 1291);
    tick();
    chk("t3 done", DONE, 1);
    chk("t3 done write", AVM_WRITE, 0);
    tick();
    chk("t3 ready", CMD_READY, 1);

    // Empty commands: W=0, then X off-screen
    start_cmd(0, 0, 0, 3, 1);
    collect(10);
    chk("t4a writes", wr_seen, 0);
    chk("t4a done cyc", done_cyc, 1);
    tick();
    chk("t4a ready", CMD_READY, 1);
    start_cmd(700, 0, 5, 1, 1);
    collect(10);
    chk("t4b writes", wr_seen, 0);
    chk("t4b done cyc", done_cyc, 1);
    tick();

    // Abort raised while the 3rd write is stalled
    start_cmd(3, 4, 8, 8, 6);
    tick();
    chk("t5 w1 addr", AVM_ADDR, 2563);
    tick();
    chk("t5 w2 addr", AVM_ADDR, 2564);
    tick();
    chk("t5 w3 addr", AVM_ADDR, 2565);
    AVM_WAITREQUEST = 1'b1;
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("t5 stall write", AVM_WRITE, 1);
    chk("t5 stall addr", AVM_ADDR, 2565);
    tick();
    AVM_WAITREQUEST = 1'b0;
    chk("t5 w3 final write", AVM_WRITE, 1);
    chk("t5 w3 final addr", AVM_ADDR, 2565);
    tick();
    chk("t5 done", DONE, 1);
    chk("t5 no 4th write", AVM_WRITE, 0);
    tick();
    chk("t5 ready", CMD_READY, 1);
    chk("t5 idle write", AVM_WRITE, 0);

    // Reset during the 5th write of a 4x4 fill
    start_cmd(1, 1, 4, 4, 12);
    for (int i = 0; i < 5; i++) tick();
    chk("t6 w5 addr", AVM_ADDR, 1281);
    RESET = 1'b0;
    tick();
    chk("t6 rst write", AVM_WRITE, 0);
    chk("t6 rst ready", CMD_READY, 1);
    chk("t6 rst done", DONE, 0);
    RESET = 1'b1;
    tick();
    chk("t6 post done", DONE, 0);
    start_cmd(2, 0, 1, 1, 3);
    collect(10);
    chk("t6 new done cyc", done_cyc, 2);
    chk("t6 new count", got_addr.size(), 1);
    if (got_addr.size() > 0) begin
      chk("t6 new addr", got_addr[0], 2);
      chk("t6 new data", got_data[0], 3);
    end
    tick();
    chk("t6 new ready", CMD_READY, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/background_fill_master.md
Name: background_fill_master

Overview:
- Avalon-MM master that fills rectangular regions of the 640x480 background color-index framebuffer with one 4-bit color index.
- Drives the background framebuffer slave port from the CPU/game-logic side, replacing per-pixel software writes.
- Accepts one fill command at a time and issues single-pixel writes at up to one per clock, honouring waitrequest.
- Row addresses are computed incrementally, so the block uses no multiplier.

Parameters:
H_RES, 640, pixels per row; also the row address stride.
V_RES, 480, rows in the frame.
ADDR_W, 19, framebuffer word address width; must satisfy H_RES*V_RES <= 2^ADDR_W.
DATA_W, 4, color index width.

Ports:
CLK  in  1  system clock, 50 MHz.
RESET  in  1  synchronous, active-low reset.
CMD_START  in  1  command strobe; accepted only while CMD_READY=1.
CMD_X  in  10  left column of the rectangle.
CMD_Y  in  10  top row of the rectangle.
CMD_W  in  10  width in pixels.
CMD_H  in  10  height in rows.
CMD_COLOR  in  DATA_W  color index to write.
ABORT  in  1  stops the fill after the in-flight write.
CMD_READY  out  1  block is idle and can accept a command.
DONE  out  1  one-cycle pulse when a command finishes (normal, empty or aborted).
AVM_CS  out  1  chip select; equals AVM_WRITE.
AVM_WRITE  out  1  write request.
AVM_ADDR  out  ADDR_W  pixel address = row*H_RES + col.
AVM_WRITEDATA  out  DATA_W  equals the latched CMD_COLOR.
AVM_BYTE_EN  out  4  constant 4'b1111.
AVM_WAITREQUEST  in  1  slave stall; a write is accepted on a rising edge where AVM_WRITE=1 and AVM_WAITREQUEST=0.

Behaviour:
- Reset (RESET=0 at a rising edge):
  - State goes to IDLE; CMD_READY=1; DONE=0; AVM_WRITE=AVM_CS=0; AVM_ADDR=0; AVM_WRITEDATA=0.
  - Reset mid-fill aborts immediately with no DONE pulse.
- IDLE: CMD_READY=1. CMD_START=1 latches X, Y, W, H and COLOR, then goes to SETUP. CMD_START is ignored in every other state.
- SETUP, one cycle, CMD_READY=0:
  - x_end = min(X+W, H_RES), 11-bit; y_end = min(Y+H, V_RES).
  - row_base = (Y<<9)+(Y<<7) for H_RES=640; a generic shift-add for other H_RES values.
  - If W=0, H=0, X>=H_RES or Y>=V_RES: go to DONE with no writes.
  - Otherwise col=X, row=Y; go to WRITE.
- WRITE:
  - AVM_WRITE=AVM_CS=1; AVM_ADDR=row_base+col; AVM_WRITEDATA=COLOR.
  - While AVM_WAITREQUEST=1, all master outputs hold stable.
  - When a write is accepted:
    - If col+1 < x_end: col++.
    - Else if row+1 < y_end: col=X, row++, row_base+=H_RES, with no bubble cycle.
    - Else: go to DONE.
  - Back-to-back writes at one per cycle when waitrequest stays low.
- ABORT in WRITE:
  - Sampled each cycle; it never drops AVM_WRITE while AVM_WAITREQUEST=1.
  - If the current write is accepted in the same cycle, or the current write is already complete, go to DONE after that write. Further writes are suppressed.
  - ABORT in IDLE or SETUP has no effect.
- DONE, one cycle: DONE=1, AVM_WRITE=0, CMD_READY=0; then IDLE.
- Latency with no stalls: START accepted at edge N; SETUP during cycle N+1; first write presented in cycle N+2. A WxH fill presents its last write in cycle N+1+W*H; DONE=1 in cycle N+2+W*H; CMD_READY=1 in cycle N+3+W*H.
- Arithmetic and clipping:
  - Addresses never exceed H_RES*V_RES-1.
  - Clipping is silent, with no error flag.
  - X+W and Y+H are computed at 11 bits, so they cannot wrap.

Test Plan:
- Reset then fill X=0,Y=0,W=4,H=1,COLOR=5, waitrequest low -> writes to addr 0,1,2,3 data 5 on consecutive cycles; DONE exactly one cycle after addr 3; CMD_READY=1 the next cycle.
- Fill X=638,Y=1,W=4,H=2 -> clipped writes to addresses 1278, 1279, 1918, 1919 only; DONE pulse.
- Fill X=10,Y=2,W=2,H=1 with AVM_WAITREQUEST=1 for 3 cycles on the first write -> addr 1290 and data held stable for 4 cycles, then 1291; exactly 2 accepted writes.
- W=0, and separately X=700 -> no AVM_WRITE assertion; DONE pulses 2 cycles after start.
- 8x8 fill with ABORT pulsed during the 3rd write while waitrequest=1 -> 3rd write completes once waitrequest drops, no 4th write, DONE pulse.
- RESET=0 during the 5th write of a 4x4 fill -> next cycle AVM_WRITE=0, CMD_READY=1, no DONE; a new CMD_START is accepted normally.
